// File: rtl/pll_lock_sequencer.sv
// PLL start-up and lock supervisor: holds the loop in reset, then qualifies lock from
// reference/feedback edge counts and PFD activity. Define PLL_LOCK_SYNC_EN for input synchronizers.
module pll_lock_sequencer #(
  parameter int unsigned WINDOW_EDGES  = 32,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned TOLERANCE     = 1,
  parameter int unsigned PHASE_MAX     = 40,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned UNLOCK_COUNT  = 2,
  parameter int unsigned MAX_WINDOWS   = 16,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             reference_clk_digital,
  input  logic             feedback_div_clk_digital,
  input  logic             output_up_digital,
  input  logic             output_down_digital,
  output logic             pll_reset_digital,
  output logic             lock_digital,
  output logic             fault_digital,
  output logic [2:0]       state_digital,
  output logic [CNT_W:0]   freq_error_real,
  output logic             window_done_digital
);

  localparam int unsigned ERR_W = CNT_W + 1;
  localparam int unsigned REF_W = $clog2(WINDOW_EDGES + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + UNLOCK_COUNT + 1);
  localparam int unsigned WIN_W = $clog2(MAX_WINDOWS + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_ACQUIRE = 3'd2,
    S_LOCKED  = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [SET_W-1:0]   settle_q, settle_n;
  logic               win_open_q, win_open_n;
  logic [REF_W-1:0]   ref_cnt_q, ref_cnt_n;
  logic [CNT_W-1:0]   fb_cnt_q, fb_cnt_n;
  logic [CNT_W-1:0]   ph_cnt_q, ph_cnt_n;
  logic [RUN_W-1:0]   good_run_q, good_run_n;
  logic [RUN_W-1:0]   bad_run_q, bad_run_n;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_n;
  logic [RTY_W-1:0]   retry_q, retry_n;
  logic               pll_reset_n, lock_n, fault_n, window_done_n;
  logic [ERR_W-1:0]   freq_err_n;
  logic               closing;

  // Input sampling: {down, up, feedback, reference}
  logic [3:0] raw_in, in_sync, samp_q;
  logic [1:0] samp_d;
  assign raw_in = {output_down_digital, output_up_digital, feedback_div_clk_digital, reference_clk_digital};

`ifdef PLL_LOCK_SYNC_EN
  logic [3:0] sync_q1, sync_q2;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
    end
  end
  assign in_sync = sync_q2;
`else
  assign in_sync = raw_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q <= '0;
      samp_d <= '0;
    end else begin
      samp_q <= in_sync;
      samp_d <= samp_q[1:0];
    end
  end

  logic ref_rise, fb_rise, phase_act;
  assign ref_rise  = samp_q[0] & ~samp_d[0];
  assign fb_rise   = samp_q[1] & ~samp_d[1];
  assign phase_act = samp_q[2] | samp_q[3];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Totals including the current cycle, used when the closing edge arrives
  logic [CNT_W-1:0] fb_tot, ph_tot;
  logic [ERR_W-1:0] diff, abs_diff;
  logic             win_good;
  assign fb_tot   = sat_inc(fb_cnt_q, fb_rise);
  assign ph_tot   = sat_inc(ph_cnt_q, phase_act);
  assign diff     = ERR_W'({1'b0, fb_tot}) - ERR_W'(WINDOW_EDGES);
  assign abs_diff = diff[ERR_W-1] ? (~diff + ERR_W'(1)) : diff;
  assign win_good = (abs_diff <= ERR_W'(TOLERANCE)) && (ph_tot <= CNT_W'(PHASE_MAX));

  always_comb begin
    state_n       = state_q;
    settle_n      = settle_q;
    win_open_n    = win_open_q;
    ref_cnt_n     = ref_cnt_q;
    fb_cnt_n      = fb_cnt_q;
    ph_cnt_n      = ph_cnt_q;
    good_run_n    = good_run_q;
    bad_run_n     = bad_run_q;
    win_cnt_n     = win_cnt_q;
    retry_n       = retry_q;
    window_done_n = 1'b0;
    freq_err_n    = freq_error_real;
    closing       = 1'b0;

    // Measurement window; the closing edge immediately opens the next one
    if ((state_q == S_ACQUIRE) || (state_q == S_LOCKED)) begin
      if (win_open_q) begin
        fb_cnt_n = fb_tot;
        ph_cnt_n = ph_tot;
        if (ref_rise) begin
          if (ref_cnt_q == REF_W'(WINDOW_EDGES - 1)) begin
            closing   = 1'b1;
            ref_cnt_n = '0;
            fb_cnt_n  = '0;
            ph_cnt_n  = '0;
          end else begin
            ref_cnt_n = ref_cnt_q + REF_W'(1);
          end
        end
      end else if (ref_rise) begin
        win_open_n = 1'b1;
        ref_cnt_n  = '0;
        fb_cnt_n   = '0;
        ph_cnt_n   = '0;
      end
    end else begin
      win_open_n = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_n  = S_HOLD;
          settle_n = '0;
        end
      end
      S_HOLD: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_n    = S_ACQUIRE;
          good_run_n = '0;
          win_cnt_n  = '0;
          win_open_n = 1'b0;
          ref_cnt_n  = '0;
          fb_cnt_n   = '0;
          ph_cnt_n   = '0;
        end else begin
          settle_n = settle_q + SET_W'(1);
        end
      end
      S_ACQUIRE: begin
        if (closing) begin
          window_done_n = 1'b1;
          freq_err_n    = diff;
          good_run_n    = win_good ? good_run_q + RUN_W'(1) : '0;
          if (win_good && (good_run_q + RUN_W'(1) == RUN_W'(LOCK_COUNT))) begin
            state_n   = S_LOCKED;
            retry_n   = '0;
            bad_run_n = '0;
          end else if (win_cnt_q + WIN_W'(1) == WIN_W'(MAX_WINDOWS)) begin
            win_cnt_n = '0;
            retry_n   = retry_q + RTY_W'(1);
            settle_n  = '0;
            state_n   = (retry_q + RTY_W'(1) == RTY_W'(MAX_RETRIES)) ? S_FAULT : S_HOLD;
          end else begin
            win_cnt_n = win_cnt_q + WIN_W'(1);
          end
        end
      end
      S_LOCKED: begin
        if (closing) begin
          window_done_n = 1'b1;
          freq_err_n    = diff;
          if (win_good) begin
            bad_run_n = '0;
          end else if (bad_run_q + RUN_W'(1) == RUN_W'(UNLOCK_COUNT)) begin
            state_n    = S_ACQUIRE;
            bad_run_n  = '0;
            good_run_n = '0;
            win_cnt_n  = '0;
          end else begin
            bad_run_n = bad_run_q + RUN_W'(1);
          end
        end
      end
      S_FAULT: ;
      default: state_n = S_IDLE;
    endcase

    // Dropping enable abandons everything, including a window closing this cycle
    if (!enable) begin
      state_n       = S_IDLE;
      retry_n       = '0;
      good_run_n    = '0;
      bad_run_n     = '0;
      win_cnt_n     = '0;
      win_open_n    = 1'b0;
      window_done_n = 1'b0;
      freq_err_n    = freq_error_real;
    end

    pll_reset_n = (state_n == S_IDLE) || (state_n == S_HOLD) || (state_n == S_FAULT);
    lock_n      = (state_n == S_LOCKED);
    fault_n     = (state_n == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= S_IDLE;
      settle_q            <= '0;
      win_open_q          <= 1'b0;
      ref_cnt_q           <= '0;
      fb_cnt_q            <= '0;
      ph_cnt_q            <= '0;
      good_run_q          <= '0;
      bad_run_q           <= '0;
      win_cnt_q           <= '0;
      retry_q             <= '0;
      pll_reset_digital   <= 1'b1;
      lock_digital        <= 1'b0;
      fault_digital       <= 1'b0;
      freq_error_real     <= '0;
      window_done_digital <= 1'b0;
    end else begin
      state_q             <= state_n;
      settle_q            <= settle_n;
      win_open_q          <= win_open_n;
      ref_cnt_q           <= ref_cnt_n;
      fb_cnt_q            <= fb_cnt_n;
      ph_cnt_q            <= ph_cnt_n;
      good_run_q          <= good_run_n;
      bad_run_q           <= bad_run_n;
      win_cnt_q           <= win_cnt_n;
      retry_q             <= retry_n;
      pll_reset_digital   <= pll_reset_n;
      lock_digital        <= lock_n;
      fault_digital       <= fault_n;
      freq_error_real     <= freq_err_n;
      window_done_digital <= window_done_n;
    end
  end

  assign state_digital = state_q;

endmodule
